// File: rtl/fp_sub_pipe.sv
// fp_sub_pipe -- three-stage pipelined IEEE-754 binary32 subtractor (res = a - b).
//
// Stages:
//   S1  unpack, magnitude compare / swap, alignment of the smaller operand
//       with guard, round and sticky bits; zero/NaN cases resolved here.
//   S2  significand add or subtract (effective operation after negating b).
//   S3  normalize, truncate toward zero, pack; S3 registers drive res/out_valid.
//
// All stages advance together when the output register is empty or being
// consumed; otherwise every stage holds.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand pair on a/b is valid
//   in_ready   pair is accepted this cycle (equals the global advance enable)
//   a, b       minuend and subtrahend, binary32
//   out_valid  res holds a completed result
//   out_ready  downstream accepts res this cycle
//   res        a - b, binary32 (denormals flushed, truncating rounding)

module fp_sub_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        adv;

  // S1 registers
  logic        s1_valid_q, s1_valid_d;
  logic        s1_special_q, s1_special_d;
  logic [31:0] s1_special_res_q, s1_special_res_d;
  logic        s1_sign_q, s1_sign_d;
  logic [7:0]  s1_exp_q, s1_exp_d;
  logic        s1_eff_sub_q, s1_eff_sub_d;
  logic [26:0] s1_sig_big_q, s1_sig_big_d;
  logic [26:0] s1_sig_small_q, s1_sig_small_d;

  // S2 registers
  logic        s2_valid_q, s2_valid_d;
  logic        s2_special_q, s2_special_d;
  logic [31:0] s2_special_res_q, s2_special_res_d;
  logic        s2_sign_q, s2_sign_d;
  logic [7:0]  s2_exp_q, s2_exp_d;
  logic [27:0] s2_mag_q, s2_mag_d;

  // S3 registers (the outputs)
  logic        out_valid_q, out_valid_d;
  logic [31:0] res_q, res_d;

  // S1 combinational intermediates
  logic        a_zero, b_zero, a_nan, b_nan, b_neg_sign, swap;
  logic [23:0] a_sig, b_sig, big_sig, small_sig;
  logic [7:0]  big_exp, small_exp, shift;
  logic [49:0] align_full;
  logic [26:0] small_ext;
  logic        special;
  logic [31:0] special_res;
  logic        big_sign;

  // S3 combinational intermediates
  logic [4:0]        lzc;
  logic              found;
  logic [26:0]       norm_sig;
  logic signed [9:0] norm_exp;
  logic [31:0]       packed_res;

  // The whole pipe moves only when the output slot can take a new value.
  assign adv       = out_ready || !out_valid_q;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign res       = res_q;

  // Unpack and align. b's sign is inverted so the rest of the datapath is a
  // plain signed-magnitude adder. The operand with the larger {exp,frac}
  // becomes the reference; on a tie a stays the reference.
  always_comb begin
    a_zero     = (a[30:23] == 8'h00);
    b_zero     = (b[30:23] == 8'h00);
    a_nan      = (a[30:23] == 8'hFF);
    b_nan      = (b[30:23] == 8'hFF);
    b_neg_sign = ~b[31];
    a_sig      = a_zero ? 24'h0 : {1'b1, a[22:0]};
    b_sig      = b_zero ? 24'h0 : {1'b1, b[22:0]};
    swap       = (b[30:0] > a[30:0]);
    big_sign   = swap ? b_neg_sign : a[31];
    big_exp    = swap ? b[30:23] : a[30:23];
    small_exp  = swap ? a[30:23] : b[30:23];
    big_sig    = swap ? b_sig : a_sig;
    small_sig  = swap ? a_sig : b_sig;
    shift      = big_exp - small_exp;

    // Bits 49:24 are significand+G+R after the shift; everything below
    // collapses into sticky. Large shifts leave only the sticky bit.
    align_full = {small_sig, 26'h0} >> shift;
    if (shift >= 8'd26) begin
      small_ext = {26'h0, |small_sig};
    end else begin
      small_ext = {align_full[49:24], |align_full[23:0]};
    end

    // Cases whose answer is known without arithmetic.
    special     = 1'b1;
    special_res = 32'h0;
    if (a_nan || b_nan) begin
      special_res = QNAN;
    end else if (a_zero && b_zero) begin
      special_res = 32'h0;
    end else if (b_zero) begin
      special_res = a;
    end else if (a_zero) begin
      special_res = {b_neg_sign, b[30:0]};
    end else begin
      special = 1'b0;
    end
  end

  always_comb begin
    s1_valid_d       = s1_valid_q;
    s1_special_d     = s1_special_q;
    s1_special_res_d = s1_special_res_q;
    s1_sign_d        = s1_sign_q;
    s1_exp_d         = s1_exp_q;
    s1_eff_sub_d     = s1_eff_sub_q;
    s1_sig_big_d     = s1_sig_big_q;
    s1_sig_small_d   = s1_sig_small_q;
    if (adv) begin
      s1_valid_d       = in_valid && in_ready;
      s1_special_d     = special;
      s1_special_res_d = special_res;
      s1_sign_d        = big_sign;
      s1_exp_d         = big_exp;
      s1_eff_sub_d     = a[31] ^ b_neg_sign;
      s1_sig_big_d     = {big_sig, 3'b000};
      s1_sig_small_d   = small_ext;
    end
  end

  // Significand add/subtract. The reference is never smaller than the
  // aligned operand, so the difference cannot go negative. Treating sticky
  // as a full LSB leaves the difference just under the exact value, which
  // truncates to the same result as the exact magnitude.
  always_comb begin
    s2_valid_d       = s2_valid_q;
    s2_special_d     = s2_special_q;
    s2_special_res_d = s2_special_res_q;
    s2_sign_d        = s2_sign_q;
    s2_exp_d         = s2_exp_q;
    s2_mag_d         = s2_mag_q;
    if (adv) begin
      s2_valid_d       = s1_valid_q;
      s2_special_d     = s1_special_q;
      s2_special_res_d = s1_special_res_q;
      s2_sign_d        = s1_sign_q;
      s2_exp_d         = s1_exp_q;
      if (s1_eff_sub_q) begin
        s2_mag_d = {1'b0, s1_sig_big_q - s1_sig_small_q};
      end else begin
        s2_mag_d = {1'b0, s1_sig_big_q} + {1'b0, s1_sig_small_q};
      end
    end
  end

  // Normalize and pack. Leading one is placed at bit 26; the low three bits
  // (G/R/S) are simply dropped, which is truncation toward zero.
  always_comb begin
    lzc   = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && s2_mag_q[i]) begin
        lzc   = 5'(26 - i);
        found = 1'b1;
      end
    end

    norm_exp = signed'({2'b00, s2_exp_q});
    if (s2_mag_q[27]) begin
      norm_sig = s2_mag_q[27:1];
      norm_exp = norm_exp + 10'sd1;
    end else begin
      norm_sig = s2_mag_q[26:0] << lzc;
      norm_exp = norm_exp - signed'({5'b00000, lzc});
    end

    if (s2_special_q) begin
      packed_res = s2_special_res_q;
    end else if (s2_mag_q == 28'h0) begin
      packed_res = 32'h0;
    end else if (norm_exp <= 10'sd0) begin
      packed_res = 32'h0;
    end else if (norm_exp >= 10'sd255) begin
      packed_res = {s2_sign_q, 8'hFF, 23'h0};
    end else begin
      packed_res = {s2_sign_q, norm_exp[7:0], 23'(norm_sig >> 3)};
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    res_d       = res_q;
    if (adv) begin
      out_valid_d = s2_valid_q;
      res_d       = packed_res;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q       <= 1'b0;
      s1_special_q     <= 1'b0;
      s1_special_res_q <= 32'h0;
      s1_sign_q        <= 1'b0;
      s1_exp_q         <= 8'h0;
      s1_eff_sub_q     <= 1'b0;
      s1_sig_big_q     <= 27'h0;
      s1_sig_small_q   <= 27'h0;
      s2_valid_q       <= 1'b0;
      s2_special_q     <= 1'b0;
      s2_special_res_q <= 32'h0;
      s2_sign_q        <= 1'b0;
      s2_exp_q         <= 8'h0;
      s2_mag_q         <= 28'h0;
      out_valid_q      <= 1'b0;
      res_q            <= 32'h0;
    end else begin
      s1_valid_q       <= s1_valid_d;
      s1_special_q     <= s1_special_d;
      s1_special_res_q <= s1_special_res_d;
      s1_sign_q        <= s1_sign_d;
      s1_exp_q         <= s1_exp_d;
      s1_eff_sub_q     <= s1_eff_sub_d;
      s1_sig_big_q     <= s1_sig_big_d;
      s1_sig_small_q   <= s1_sig_small_d;
      s2_valid_q       <= s2_valid_d;
      s2_special_q     <= s2_special_d;
      s2_special_res_q <= s2_special_res_d;
      s2_sign_q        <= s2_sign_d;
      s2_exp_q         <= s2_exp_d;
      s2_mag_q         <= s2_mag_d;
      out_valid_q      <= out_valid_d;
      res_q            <= res_d;
    end
  end

endmodule
